meas_sampler: RTL and testbench
===============================

Name: meas_sampler

Overview:
- Measurement responder between the calibration FSM (initiator) and the plant ADC stream.
- On each measurement request it waits a thermal-settle interval, then accumulates a fixed number of ADC samples per output channel.
- It returns truncated per-channel averages plus per-channel saturation and timeout flags over a valid/ready response handshake.
- It serves both unitary and SVD calibration loops. It is mode-agnostic.

Parameters:
- ADC_WIDTH, 12, ADC sample width, unsigned codes 0..2^ADC_WIDTH-1.
- NUM_OUTPUTS, 2, number of ADC channels.
- SETTLE_CYCLES, 16, clock cycles to wait after request accept. 0 is legal.
- AVG_SAMPLES, 8, samples averaged per measurement. Must be a power of two, ≥1.
- TIMEOUT_CYCLES, 1024, maximum consecutive cycles in ACCUM without adc_valid before the block gives up.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  measurement request.
- req_ready  out  1  high only in IDLE.
- abort  in  1  synchronous cancel of the in-flight measurement.
- adc_valid  in  1  adc_data is valid this cycle.
- adc_data  in  NUM_OUTPUTS*ADC_WIDTH  channel c at bits [c*ADC_WIDTH +: ADC_WIDTH].
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  NUM_OUTPUTS*ADC_WIDTH  per-channel averages, same packing as adc_data.
- resp_sat  out  NUM_OUTPUTS  bit c set if any accumulated channel-c sample was 0 or all-ones.
- resp_timeout  out  1  measurement ended by timeout.
- busy  out  1  state != IDLE.

Behaviour:
- **Reset** (rst_n=0 at posedge): state=IDLE. req_ready=1, resp_valid=0, resp_data=0, resp_sat=0, resp_timeout=0, busy=0. All counters and accumulators are cleared. Reset overrides every other input, including mid-measurement.
- **States:** IDLE, SETTLE, ACCUM, RESP.
- **IDLE:** req_valid && req_ready accepts the request at cycle 0.
  - Next state is SETTLE with settle_cnt = SETTLE_CYCLES-1, or ACCUM directly if SETTLE_CYCLES=0.
  - Accumulators, sample count, sat bits and timeout counter are cleared on accept.
- **SETTLE:** adc_valid and adc_data are ignored. The state lasts exactly SETTLE_CYCLES cycles (cycles 1..SETTLE_CYCLES), then moves to ACCUM.
- **ACCUM:** each cycle with adc_valid=1:
  - acc[c] += adc_data[c]. Accumulator width is ADC_WIDTH+log2(AVG_SAMPLES), so no overflow.
  - sample_cnt increments.
  - sat[c] |= (sample==0 || sample==all-ones).
  - The timeout counter resets to 0.
- **ACCUM completion:** when the AVG_SAMPLES-th sample is accepted:
  - Next cycle is RESP with resp_data[c] = acc_final[c] >> log2(AVG_SAMPLES). This is truncation toward zero.
  - resp_sat=sat and resp_timeout=0.
- **Latency:** with continuous adc_valid, resp_valid rises at cycle SETTLE_CYCLES+AVG_SAMPLES+1 after accept (25 for defaults).
- **Timeout:** each ACCUM cycle with adc_valid=0 increments the timeout counter. When it reaches TIMEOUT_CYCLES, next state is RESP with resp_timeout=1, resp_data=0 and resp_sat=accumulated sat.
- **RESP:** resp_valid=1.
  - resp_data, resp_sat and resp_timeout are held stable until resp_valid && resp_ready.
  - The state then returns to IDLE next cycle. A new request cannot be accepted in the handshake cycle, so there is at least one cycle between response and next accept.
  - resp_* registers keep their last values after the handshake; only resp_valid drops.
- **abort=1 in SETTLE/ACCUM/RESP:** next state is IDLE, resp_valid=0 next cycle, and no response is produced. Accumulators are cleared. abort in IDLE is a no-op. abort has priority over completion, timeout and the response handshake in the same cycle.
- **adc_valid in IDLE/RESP:** ignored.

Test Plan:
- **Constant input.** Continuous adc_valid, ch0=0x400, ch1=0x123, defaults -> resp_valid exactly 25 cycles after accept; resp_data ch0=0x400, ch1=0x123; resp_sat=2'b00; resp_timeout=0.
- **Truncation and settle masking.** ch0 samples 0xFFF during SETTLE, then 1..8 in ACCUM -> ch0 avg = 36>>3 = 4 (truncated from 4.5); resp_sat[0]=0 because settle samples are ignored. Repeat with ch1 containing one 0xFFF and one 0x000 in ACCUM -> resp_sat=2'b10.
- **Gaps and backpressure.** adc_valid asserted every 3rd cycle -> resp_valid 16+22+1=39 cycles after accept. Hold resp_ready=0 for 5 cycles -> outputs stable throughout; req_ready rises the cycle after the handshake.
- **Abort.** abort during ACCUM after 3 samples -> busy=0 and req_ready=1 next cycle, no resp_valid. A following request with constant 0x200 returns 0x200, proving accumulators were cleared.
- **Timeout.** TIMEOUT_CYCLES=8, 2 samples then adc_valid=0 -> RESP with resp_timeout=1, resp_data=0, 8 idle cycles after the last sample.
- **Reset and SETTLE_CYCLES=0.** rst_n low mid-SETTLE -> all outputs at reset values next cycle. With SETTLE_CYCLES=0 and continuous samples -> resp_valid 9 cycles after accept.

Source files
------------

// File: rtl/meas_sampler.sv
// Measurement responder: after a request it waits a settle interval, averages
// AVG_SAMPLES ADC samples per channel, and returns averages, saturation flags
// and a timeout flag over a valid/ready response handshake.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   measurement request handshake (ready only in IDLE)
//   abort             cancel the in-flight measurement, no response produced
//   adc_valid/data    ADC stream, channel c at [c*ADC_WIDTH +: ADC_WIDTH]
//   resp_valid/ready  response handshake
//   resp_data         per-channel truncated averages, same packing as adc_data
//   resp_sat          per-channel: some accumulated sample was 0 or all-ones
//   resp_timeout      measurement ended because the ADC stream stalled
//   busy              not in IDLE
module meas_sampler #(
    parameter int unsigned ADC_WIDTH      = 12,
    parameter int unsigned NUM_OUTPUTS    = 2,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned AVG_SAMPLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             abort,
    input  logic                             adc_valid,
    input  logic [NUM_OUTPUTS*ADC_WIDTH-1:0] adc_data,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [NUM_OUTPUTS*ADC_WIDTH-1:0] resp_data,
    output logic [NUM_OUTPUTS-1:0]           resp_sat,
    output logic                             resp_timeout,
    output logic                             busy
);

    localparam int unsigned SHIFT = $clog2(AVG_SAMPLES);
    localparam int unsigned ACC_W = ADC_WIDTH + SHIFT;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned CNT_W = $clog2(AVG_SAMPLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADC_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {StIdle, StSettle, StAccum, StResp} state_e;

    state_e state_q, state_d;

    logic [SET_W-1:0]                 settle_cnt_q;
    logic [CNT_W-1:0]                 sample_cnt_q;
    logic [TO_W-1:0]                  to_cnt_q;
    logic [ACC_W-1:0]                 acc_q [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0]           sat_q;
    logic [NUM_OUTPUTS*ADC_WIDTH-1:0] resp_data_q;
    logic [NUM_OUTPUTS-1:0]           resp_sat_q;
    logic                             resp_timeout_q;

    logic [ACC_W-1:0]       acc_sum [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] samp_sat;
    logic                   accept, active_abort, sample_fire, last_sample, idle_tick, to_hit;

    // Per-channel sum including the current sample, and its saturation flag.
    always_comb begin
        for (int unsigned c = 0; c < NUM_OUTPUTS; c++) begin
            acc_sum[c]  = acc_q[c] + ACC_W'(adc_data[c*ADC_WIDTH +: ADC_WIDTH]);
            samp_sat[c] = (adc_data[c*ADC_WIDTH +: ADC_WIDTH] == '0) ||
                          (adc_data[c*ADC_WIDTH +: ADC_WIDTH] == ALL_ONES);
        end
    end

    // abort outranks every other event outside IDLE.
    assign accept       = (state_q == StIdle) && req_valid;
    assign active_abort = (state_q != StIdle) && abort;
    assign sample_fire  = (state_q == StAccum) && adc_valid && !abort;
    assign last_sample  = sample_fire && (sample_cnt_q == CNT_W'(AVG_SAMPLES - 1));
    assign idle_tick    = (state_q == StAccum) && !adc_valid && !abort;
    assign to_hit       = idle_tick && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = (SETTLE_CYCLES == 0) ? StAccum : StSettle;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (settle_cnt_q == '0) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (last_sample || to_hit) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (abort || resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        busy       = (state_q != StIdle);
    end

    // Datapath: counters, accumulators and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt_q   <= '0;
            sample_cnt_q   <= '0;
            to_cnt_q       <= '0;
            sat_q          <= '0;
            resp_data_q    <= '0;
            resp_sat_q     <= '0;
            resp_timeout_q <= 1'b0;
            for (int unsigned c = 0; c < NUM_OUTPUTS; c++) acc_q[c] <= '0;
        end else if (accept || active_abort) begin
            settle_cnt_q <= (SETTLE_CYCLES == 0) ? '0 : SET_W'(SETTLE_CYCLES - 1);
            sample_cnt_q <= '0;
            to_cnt_q     <= '0;
            sat_q        <= '0;
            for (int unsigned c = 0; c < NUM_OUTPUTS; c++) acc_q[c] <= '0;
        end else begin
            if (state_q == StSettle && settle_cnt_q != '0) begin
                settle_cnt_q <= settle_cnt_q - 1'b1;
            end
            if (sample_fire) begin
                sample_cnt_q <= sample_cnt_q + 1'b1;
                to_cnt_q     <= '0;
                sat_q        <= sat_q | samp_sat;
                for (int unsigned c = 0; c < NUM_OUTPUTS; c++) acc_q[c] <= acc_sum[c];
            end else if (idle_tick) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (last_sample) begin
                // Average is the top ADC_WIDTH bits of the final sum (truncating).
                for (int unsigned c = 0; c < NUM_OUTPUTS; c++) begin
                    resp_data_q[c*ADC_WIDTH +: ADC_WIDTH] <= acc_sum[c][SHIFT +: ADC_WIDTH];
                end
                resp_sat_q     <= sat_q | samp_sat;
                resp_timeout_q <= 1'b0;
            end else if (to_hit) begin
                resp_data_q    <= '0;
                resp_sat_q     <= sat_q;
                resp_timeout_q <= 1'b1;
            end
        end
    end

    assign resp_data    = resp_data_q;
    assign resp_sat     = resp_sat_q;
    assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_meas_sampler.sv
// Scoreboard bench for meas_sampler. Two instances: u_dut (settle 16) and
// u_dut0 (settle 0); both use an 8-cycle timeout. sel chooses which one the
// stimulus addresses and whose outputs are observed.
module tb_meas_sampler;

    localparam int TB_TO = 8;
    localparam int NAVG  = 8;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, abort, adc_valid, resp_ready;
    logic [23:0] adc_data;
    int          sel;

    logic        rr0, rv0, to0, bz0, rr1, rv1, to1, bz1;
    logic [23:0] rd0, rd1;
    logic [1:0]  rs0, rs1;
    logic        req_v0, req_v1;

    logic        req_ready_o, resp_valid_o, resp_timeout_o, busy_o;
    logic [23:0] resp_data_o;
    logic [1:0]  resp_sat_o;

    assign req_v0 = req_valid && (sel == 0);
    assign req_v1 = req_valid && (sel == 1);

    assign req_ready_o    = (sel == 0) ? rr0 : rr1;
    assign resp_valid_o   = (sel == 0) ? rv0 : rv1;
    assign resp_timeout_o = (sel == 0) ? to0 : to1;
    assign busy_o         = (sel == 0) ? bz0 : bz1;
    assign resp_data_o    = (sel == 0) ? rd0 : rd1;
    assign resp_sat_o     = (sel == 0) ? rs0 : rs1;

    meas_sampler #(.ADC_WIDTH(12), .NUM_OUTPUTS(2), .SETTLE_CYCLES(16), .AVG_SAMPLES(NAVG),
                   .TIMEOUT_CYCLES(TB_TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_v0), .req_ready(rr0), .abort(abort),
        .adc_valid(adc_valid), .adc_data(adc_data), .resp_valid(rv0), .resp_ready(resp_ready),
        .resp_data(rd0), .resp_sat(rs0), .resp_timeout(to0), .busy(bz0)
    );

    meas_sampler #(.ADC_WIDTH(12), .NUM_OUTPUTS(2), .SETTLE_CYCLES(0), .AVG_SAMPLES(NAVG),
                   .TIMEOUT_CYCLES(TB_TO)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_v1), .req_ready(rr1), .abort(abort),
        .adc_valid(adc_valid), .adc_data(adc_data), .resp_valid(rv1), .resp_ready(resp_ready),
        .resp_data(rd1), .resp_sat(rs1), .resp_timeout(to1), .busy(bz1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic [1:0]  sat;
        logic        to;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [11:0] s0[NAVG];
    logic [11:0] s1[NAVG];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_const(input logic [11:0] a, input logic [11:0] b);
        for (int i = 0; i < NAVG; i++) begin
            s0[i] = a;
            s1[i] = b;
        end
    endtask

    // Reference: expected response and cycle (after accept) where resp_valid rises.
    function automatic exp_t model(input int settle, input int gap, input int nsamp);
        exp_t e;
        int   sum0, sum1, last;
        sum0  = 0;
        sum1  = 0;
        e.sat = 2'b00;
        for (int i = 0; i < nsamp; i++) begin
            sum0 += int'(s0[i]);
            sum1 += int'(s1[i]);
            if (s0[i] == 12'h000 || s0[i] == 12'hFFF) e.sat[0] = 1'b1;
            if (s1[i] == 12'h000 || s1[i] == 12'hFFF) e.sat[1] = 1'b1;
        end
        last = settle + 1 + (nsamp - 1) * gap;
        if (nsamp == NAVG) begin
            e.data = {12'(sum1 / NAVG), 12'(sum0 / NAVG)};
            e.to   = 1'b0;
            e.lat  = last + 1;
        end else begin
            e.data = 24'h0;
            e.to   = 1'b1;
            e.lat  = last + TB_TO + 1;
        end
        return e;
    endfunction

    // One measurement on the selected DUT. SETTLE cycles carry valid 0xFFF data
    // that must be ignored. abort_after>0 aborts once that many samples went in.
    task automatic do_meas(input int settle, input int gap, input int nsamp, input int hold,
                           input int abort_after);
        exp_t e;
        int   k, j, any;
        bit   seen;
        check_val("req_ready_pre_accept", req_ready_o, 1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        if (abort_after == 0) sb_q.push_back(model(settle, gap, nsamp));
        k    = 1;
        j    = 0;
        seen = 1'b0;
        while (!seen && k <= 300) begin
            if (resp_valid_o) begin
                seen = 1'b1;
            end else begin
                if (abort_after > 0 && j == abort_after) begin
                    abort     = 1'b1;
                    adc_valid = 1'b1;
                    adc_data  = 24'hFFFFFF;
                    tick();
                    abort     = 1'b0;
                    adc_valid = 1'b0;
                    check_val("abort_busy", busy_o, 0);
                    check_val("abort_req_ready", req_ready_o, 1);
                    check_val("abort_resp_valid", resp_valid_o, 0);
                    any = 0;
                    repeat (30) begin
                        if (resp_valid_o) any = 1;
                        tick();
                    end
                    check_val("abort_no_resp", any, 0);
                    return;
                end
                if (k <= settle) begin
                    adc_valid = 1'b1;
                    adc_data  = 24'hFFFFFF;
                end else if (j < nsamp && ((k - settle - 1) % gap) == 0) begin
                    adc_valid = 1'b1;
                    adc_data  = {s1[j], s0[j]};
                    j++;
                end else begin
                    adc_valid = 1'b0;
                    adc_data  = 24'hFFF000;
                end
                tick();
                k++;
            end
        end
        adc_valid = 1'b0;
        if (!seen) begin
            check_val("resp_valid_wait_expired", 0, 1);
            return;
        end
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty_on_resp", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check_val("resp_latency", k, e.lat);
        check_val("resp_data", resp_data_o, e.data);
        check_val("resp_sat", resp_sat_o, e.sat);
        check_val("resp_timeout", resp_timeout_o, e.to);
        check_val("busy_in_resp", busy_o, 1);
        for (int h = 0; h < hold; h++) begin
            resp_ready = 1'b0;
            tick();
            check_val("resp_hold_stable", {resp_valid_o, resp_timeout_o, resp_sat_o, resp_data_o},
                      {1'b1, e.to, e.sat, e.data});
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_val("post_hs_req_ready", req_ready_o, 1);
        check_val("post_hs_resp_valid", resp_valid_o, 0);
        check_val("post_hs_data_kept", {resp_timeout_o, resp_sat_o, resp_data_o},
                  {e.to, e.sat, e.data});
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        abort      = 1'b0;
        adc_valid  = 1'b0;
        adc_data   = 24'h0;
        resp_ready = 1'b0;
        sel        = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            check_val("reset_outputs",
                      {req_ready_o, resp_valid_o, busy_o, resp_timeout_o, resp_sat_o, resp_data_o},
                      {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 24'h0});
        end
        sel = 0;

        // Constant input
        set_const(12'h400, 12'h123);
        do_meas(16, 1, 8, 0, 0);

        // Reset in the middle of SETTLE
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        adc_valid = 1'b1;
        adc_data  = 24'hFFFFFF;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        adc_valid = 1'b0;
        check_val("reset_mid_settle",
                  {req_ready_o, resp_valid_o, busy_o, resp_timeout_o, resp_sat_o, resp_data_o},
                  {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 24'h0});
        tick();

        // Truncation (36>>3 = 4) with settle samples masked
        for (int i = 0; i < NAVG; i++) begin
            s0[i] = 12'(i + 1);
            s1[i] = 12'h123;
        end
        do_meas(16, 1, 8, 0, 0);

        // Saturation on channel 1 only
        for (int i = 0; i < NAVG; i++) s1[i] = 12'h005;
        s1[2] = 12'hFFF;
        s1[5] = 12'h000;
        do_meas(16, 1, 8, 0, 0);

        // Samples every 3rd cycle, response held off for 5 cycles
        for (int i = 0; i < NAVG; i++) begin
            s0[i] = 12'(12'h111 * (i + 1));
            s1[i] = 12'h777;
        end
        do_meas(16, 3, 8, 5, 0);

        // Abort after 3 samples, then a clean measurement
        set_const(12'h300, 12'h3FF);
        do_meas(16, 1, 8, 0, 3);
        set_const(12'h200, 12'h200);
        do_meas(16, 1, 8, 0, 0);

        // Timeout: 2 samples then the stream stalls
        set_const(12'h010, 12'h050);
        s0[0] = 12'hFFF;
        s1[1] = 12'h060;
        do_meas(16, 1, 2, 2, 0);

        // Zero settle instance
        sel = 1;
        #1;
        set_const(12'h0FF, 12'h700);
        do_meas(0, 1, 8, 0, 0);

        check_val("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
